mem_resp_queue: RTL

Parametrised MEM-stage data-response tracker for the pipelined CPU: records every data request accepted by the data SRAM interface and matches in-order `data_ok` responses to it, with up to DEPTH requests in flight. Each response is buffered, byte/half/word/dword-extracted and sign/zero-extended, then presented to WB under a valid/ready handshake. A WB exception flush cancels every in-flight request; late responses for cancelled requests are absorbed silently. Successor to the single-outstanding MEM buffer: parametrised data width, multiple outstanding requests, and flush-safe response draining.

---
 rtl/mem_resp_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_queue
// Purpose  : MEM-stage data-response tracker. Records each data request
//            accepted by the data SRAM interface, matches in-order data_ok
//            responses to it (up to DEPTH in flight), extracts and extends
//            the load result, and hands it to WB under valid/ready.
//            A flush cancels every in-flight entry; responses that arrive
//            later for cancelled entries are drained silently.
// Ports    : clk, resetn (async, active low)
//            req_issue/req_op/req_off : request accepted this cycle
//            can_issue                : queue not full
//            data_ok/rdata            : in-order memory response
//            flush                    : cancel all in-flight entries
//            resp_valid/resp_data/resp_ready : WB handshake
//            outstanding              : live entries, cancelled included
// Revision : 1.0 - initial multi-outstanding release
// ============================================================================
module mem_resp_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int OFF_W  = $clog2(DATA_W / 8),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_issue,
    input  logic [2:0]        req_op,
    input  logic [OFF_W-1:0]  req_off,
    output logic              can_issue,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    input  logic              resp_ready,
    output logic [CNT_W-1:0]  outstanding
);

    localparam int c_IDX_W = $clog2(DEPTH);

    localparam logic [2:0] c_EMPTY     = 3'd0;
    localparam logic [2:0] c_WAIT      = 3'd1;
    localparam logic [2:0] c_DONE      = 3'd2;
    localparam logic [2:0] c_KILL_WAIT = 3'd3;
    localparam logic [2:0] c_KILL_DONE = 3'd4;

    localparam logic [2:0] c_OP_LB  = 3'd0;
    localparam logic [2:0] c_OP_LBU = 3'd1;
    localparam logic [2:0] c_OP_LH  = 3'd2;
    localparam logic [2:0] c_OP_LHU = 3'd3;
    localparam logic [2:0] c_OP_LW  = 3'd4;
    localparam logic [2:0] c_OP_LD  = 3'd6;

    logic [2:0]        r_state [DEPTH];
    logic [2:0]        r_op    [DEPTH];
    logic [OFF_W-1:0]  r_off   [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rsp_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;

    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rsp_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_full;
    logic               w_issue;
    logic               w_resp;
    logic               w_bypass;
    logic               w_pop;
    logic [2:0]         w_head_st;
    logic [2:0]         w_head_op;
    logic [OFF_W-1:0]   w_head_off;
    logic [DATA_W-1:0]  w_src;
    logic [OFF_W-1:0]   w_off_h;
    logic [OFF_W-1:0]   w_off_w;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_word;
    logic [DATA_W-1:0]  w_ext;

    assign w_wr_idx  = r_wr_ptr[c_IDX_W-1:0];
    assign w_rsp_idx = r_rsp_ptr[c_IDX_W-1:0];
    assign w_rd_idx  = r_rd_ptr[c_IDX_W-1:0];

    // Full when the indices meet but the wrap bits differ.
    assign w_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]);
    assign can_issue = ~w_full;
    assign w_issue   = req_issue & ~w_full;
    assign w_resp    = data_ok & (r_rsp_ptr != r_wr_ptr);

    assign w_head_st  = r_state[w_rd_idx];
    assign w_head_op  = r_op[w_rd_idx];
    assign w_head_off = r_off[w_rd_idx];

    // Head is still waiting and its data arrives now: present it straight
    // from rdata so a ready WB sees zero-cycle load latency.
    assign w_bypass = (w_head_st == c_WAIT) && (r_rsp_ptr == r_rd_ptr) && data_ok && !flush;

    assign resp_valid = !flush && ((w_head_st == c_DONE) || w_bypass);

    // Killed heads drain on their own; live heads need the WB handshake.
    assign w_pop = (resp_valid && resp_ready) || (w_head_st == c_KILL_DONE);

    assign outstanding = r_wr_ptr - r_rd_ptr;

    always_comb begin
        w_src   = w_bypass ? rdata : r_data[w_rd_idx];
        w_off_h = w_head_off & ~OFF_W'(1);
        w_off_w = w_head_off & ~OFF_W'(3);
        w_byte  = 8'(w_src >> {w_head_off, 3'b000});
        w_half  = 16'(w_src >> {w_off_h, 3'b000});
        w_word  = 32'(w_src >> {w_off_w, 3'b000});
        w_ext   = '0;
        case (w_head_op)
            c_OP_LB:  w_ext = DATA_W'($signed(w_byte));
            c_OP_LBU: w_ext = DATA_W'(w_byte);
            c_OP_LH:  w_ext = DATA_W'($signed(w_half));
            c_OP_LHU: w_ext = DATA_W'(w_half);
            c_OP_LW:  w_ext = DATA_W'($signed(w_word));
            c_OP_LD:  w_ext = (DATA_W == 64) ? w_src : DATA_W'($signed(w_word));
            default:  w_ext = '0;
        endcase
    end

    assign resp_data = resp_valid ? w_ext : '0;

    // Later assignments in the loop body take priority: flush marking,
    // then response capture, then allocation, and finally pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rsp_ptr <= '0;
            r_rd_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= c_EMPTY;
                r_op[i]    <= '0;
                r_off[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_issue) r_wr_ptr  <= r_wr_ptr + CNT_W'(1);
            if (w_resp)  r_rsp_ptr <= r_rsp_ptr + CNT_W'(1);
            if (w_pop)   r_rd_ptr  <= r_rd_ptr + CNT_W'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    if (r_state[i] == c_WAIT) r_state[i] <= c_KILL_WAIT;
                    if (r_state[i] == c_DONE) r_state[i] <= c_KILL_DONE;
                end
                if (w_resp && (w_rsp_idx == c_IDX_W'(i))) begin
                    r_data[i]  <= rdata;
                    r_state[i] <= (flush || (r_state[i] == c_KILL_WAIT)) ? c_KILL_DONE : c_DONE;
                end
                if (w_issue && (w_wr_idx == c_IDX_W'(i))) begin
                    r_state[i] <= flush ? c_KILL_WAIT : c_WAIT;
                    r_op[i]    <= req_op;
                    r_off[i]   <= req_off;
                end
                if (w_pop && (w_rd_idx == c_IDX_W'(i))) begin
                    r_state[i] <= c_EMPTY;
                end
            end
        end
    end

endmodule
`default_nettype wire
